// File: rtl/bus_fabric.sv
// CPU-side interconnect for the picorv32 memory bus: slot decode on mem_addr[31:28],
// per-slot fixed or handshaked completion, watchdog timeout and bus-error capture.
`timescale 1ns/1ps
module bus_fabric #(
    parameter int          NSLV     = 8,
    parameter logic [63:0] LAT      = 64'h1111_1111_1111_1111,
    parameter logic [15:0] EXT_RDY  = 16'h0000,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                 clk24,
    input  logic                 reset,
    input  logic                 mem_valid,
    input  logic [31:0]          mem_addr,
    input  logic [3:0]           mem_wstrb,
    output logic [31:0]          mem_rdata,
    output logic                 mem_ready,
    output logic [NSLV-1:0]      slv_sel,
    input  logic [32*NSLV-1:0]   slv_rdata,
    input  logic [NSLV-1:0]      slv_rdy,
    output logic                 err,
    output logic [31:0]          err_addr,
    output logic [7:0]           err_cnt,
    input  logic                 err_clr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_cnt, w_cnt_next;
    logic [3:0]  r_slot, w_slot_next;
    logic [31:0] r_addr, w_addr_next;
    logic        r_err_done, w_err_done_next;
    logic        r_guard, w_guard_next;
    logic        r_err;
    logic [31:0] r_err_addr;
    logic [7:0]  r_err_cnt;
    logic        w_err_event;

    logic [3:0]  w_req_slot;
    logic        w_hit;
    logic [3:0]  w_req_lat, w_cur_lat;
    logic        w_req_ext, w_cur_ext, w_cur_rdy;
    logic [31:0] w_cur_rdata;
    logic        w_unused;

    // Per-slot tables padded to the full 16-slot address space; absent slots read as zero.
    logic [3:0]  w_lat_arr   [16];
    logic        w_ext_arr   [16];
    logic        w_rdy_arr   [16];
    logic [31:0] w_rdata_arr [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_slot_tab
        assign w_lat_arr[gi] = LAT[4*gi +: 4];
        assign w_ext_arr[gi] = EXT_RDY[gi];
        if (gi < NSLV) begin : g_present
            assign w_rdy_arr[gi]   = slv_rdy[gi];
            assign w_rdata_arr[gi] = slv_rdata[32*gi +: 32];
        end else begin : g_absent
            assign w_rdy_arr[gi]   = 1'b0;
            assign w_rdata_arr[gi] = 32'd0;
        end
    end

    assign w_req_slot  = mem_addr[31:28];
    assign w_hit       = mem_valid & ({1'b0, w_req_slot} < 5'(NSLV));
    assign w_req_lat   = w_lat_arr[w_req_slot];
    assign w_req_ext   = w_ext_arr[w_req_slot];
    assign w_cur_lat   = w_lat_arr[r_slot];
    assign w_cur_ext   = w_ext_arr[r_slot];
    assign w_cur_rdy   = w_rdy_arr[r_slot];
    assign w_cur_rdata = w_rdata_arr[r_slot];
    assign w_unused    = ^mem_wstrb;

    // Select is combinational so synchronous slave memories see the address in cycle 0.
    for (genvar gi = 0; gi < NSLV; gi++) begin : g_sel
        assign slv_sel[gi] = mem_valid & ~reset & (w_req_slot == 4'(gi)) & (r_state != S_DONE);
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_slot_next     = r_slot;
        w_addr_next     = r_addr;
        w_err_done_next = r_err_done;
        w_guard_next    = 1'b0;
        w_err_event     = 1'b0;
        mem_ready       = 1'b0;
        mem_rdata       = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (mem_valid && !r_guard) begin
                    w_slot_next = w_req_slot;
                    w_addr_next = mem_addr;
                    w_cnt_next  = 16'd1;
                    if (!w_hit) begin
                        w_state_next    = S_DONE;
                        w_err_done_next = 1'b1;
                    end else if (!w_req_ext && (w_req_lat <= 4'd1)) begin
                        w_state_next    = S_DONE;
                        w_err_done_next = 1'b0;
                    end else begin
                        w_state_next    = S_WAIT;
                        w_err_done_next = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt + 16'd1;
                if (!mem_valid) begin
                    // Abandoned request: quietly return without ready or error.
                    w_state_next = S_IDLE;
                    w_cnt_next   = 16'd0;
                end else if (w_cur_ext && w_cur_rdy) begin
                    mem_ready    = 1'b1;
                    mem_rdata    = w_cur_rdata;
                    w_state_next = S_IDLE;
                    w_guard_next = 1'b1;
                    w_cnt_next   = 16'd0;
                end else if (!w_cur_ext && (r_cnt == 16'(w_cur_lat) - 16'd1)) begin
                    w_state_next = S_DONE;
                end else if (r_cnt == 16'(TIMEOUT)) begin
                    w_state_next    = S_DONE;
                    w_err_done_next = 1'b1;
                end
            end
            S_DONE: begin
                mem_ready       = 1'b1;
                mem_rdata       = r_err_done ? ERR_DATA : w_cur_rdata;
                w_err_event     = r_err_done;
                w_state_next    = S_IDLE;
                w_guard_next    = 1'b1;
                w_cnt_next      = 16'd0;
                w_err_done_next = 1'b0;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_slot     <= 4'd0;
            r_addr     <= 32'd0;
            r_err_done <= 1'b0;
            r_guard    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_slot     <= w_slot_next;
            r_addr     <= w_addr_next;
            r_err_done <= w_err_done_next;
            r_guard    <= w_guard_next;
        end
    end

    // A simultaneous clear and error restarts capture from the new error.
    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            r_err      <= 1'b0;
            r_err_addr <= 32'd0;
            r_err_cnt  <= 8'd0;
        end else if (w_err_event) begin
            r_err <= 1'b1;
            if (!r_err || err_clr) begin
                r_err_addr <= r_addr;
            end
            if (err_clr) begin
                r_err_cnt <= 8'd1;
            end else if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end else if (err_clr) begin
            r_err      <= 1'b0;
            r_err_addr <= 32'd0;
            r_err_cnt  <= 8'd0;
        end
    end

    assign err      = r_err;
    assign err_addr = r_err_addr;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: directed and random transactions against a
// latency/data/error model derived from the slot configuration.
`timescale 1ns/1ps
module tb_bus_fabric;

    localparam int NS = 6;

    logic           clk24 = 1'b0;
    logic           reset;
    logic           mem_valid;
    logic [31:0]    mem_addr;
    logic [3:0]     mem_wstrb;
    logic [31:0]    mem_rdata;
    logic           mem_ready;
    logic [NS-1:0]  slv_sel;
    logic [32*NS-1:0] slv_rdata;
    logic [NS-1:0]  slv_rdy;
    logic           err;
    logic [31:0]    err_addr;
    logic [7:0]     err_cnt;
    logic           err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the error capture registers.
    bit          m_err;
    logic [31:0] m_addr;
    int          m_cnt;

    // Configured fixed latencies per slot (slot 4 is handshaked).
    int lat_tab [NS] = '{1, 3, 0, 2, 15, 7};

    bus_fabric #(
        .NSLV    (NS),
        .LAT     (64'h0000_0000_007F_2031),
        .EXT_RDY (16'h0010),
        .TIMEOUT (16),
        .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk24    (clk24),
        .reset    (reset),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .slv_sel  (slv_sel),
        .slv_rdata(slv_rdata),
        .slv_rdy  (slv_rdy),
        .err      (err),
        .err_addr (err_addr),
        .err_cnt  (err_cnt),
        .err_clr  (err_clr)
    );

    always #5 clk24 = ~clk24;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_err_regs(input string tag);
        check_eq({tag, "_err"},      32'(err),      32'(m_err));
        check_eq({tag, "_err_addr"}, err_addr,      m_addr);
        check_eq({tag, "_err_cnt"},  32'(err_cnt),  32'(m_cnt));
    endtask

    // One CPU transaction; cycle 0 is the first cycle mem_valid is seen by an idle fabric.
    task automatic run_txn(input logic [31:0] addr, input int rdy_d, input bit clr_at_ready);
        int          slot;
        bit          mapped, ext, exp_err, sel_ok;
        int          exp_cyc, got_cyc;
        logic [31:0] exp_data, got_data;
        logic [NS-1:0] exp_sel;
        slot    = int'(addr[31:28]);
        mapped  = slot < NS;
        ext     = (slot == 4);
        exp_err = !mapped || (ext && rdy_d > 16);
        if (!mapped)      exp_cyc = 1;
        else if (ext)     exp_cyc = (rdy_d > 16) ? 17 : rdy_d;
        else              exp_cyc = (lat_tab[slot] < 1) ? 1 : lat_tab[slot];
        for (int i = 0; i < NS; i++) slv_rdata[32*i +: 32] = $urandom();
        if (exp_err) exp_data = 32'hDEAD_BEEF;
        else         exp_data = slv_rdata[32*slot +: 32];
        exp_sel  = mapped ? NS'(1 << slot) : '0;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = 4'($urandom());
        got_cyc   = -1;
        got_data  = 32'd0;
        sel_ok    = 1'b1;
        for (int c = 0; c < 40; c++) begin
            slv_rdy = (ext && c == rdy_d) ? NS'(1 << 4) : '0;
            err_clr = clr_at_ready && (c == exp_cyc);
            @(negedge clk24);
            if (mem_ready) begin
                got_cyc  = c;
                got_data = mem_rdata;
                break;
            end
            if (slv_sel !== exp_sel) sel_ok = 1'b0;
            @(posedge clk24); #1;
        end
        check_eq("ready_cycle", 32'(got_cyc), 32'(exp_cyc));
        check_eq("rdata", got_data, exp_data);
        check_eq("sel_during_wait", 32'(sel_ok), 32'd1);
        // CPU holds mem_valid one cycle past ready: no second completion allowed.
        @(posedge clk24); #1;
        slv_rdy = '0;
        err_clr = 1'b0;
        if (exp_err) begin
            if (clr_at_ready) begin
                m_err = 1'b1; m_addr = addr; m_cnt = 1;
            end else begin
                if (!m_err) m_addr = addr;
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end else if (clr_at_ready) begin
            m_err = 1'b0; m_addr = 32'd0; m_cnt = 0;
        end
        @(negedge clk24);
        check_eq("no_dup_ready", 32'(mem_ready), 32'd0);
        check_eq("rdata_idle", mem_rdata, 32'd0);
        check_err_regs("txn");
        $display("txn addr=%h slot=%0d rdy_d=%0d clr=%0d ready_cyc=%0d rdata=%h err_cnt=%0d",
                 addr, slot, rdy_d, clr_at_ready, got_cyc, got_data, err_cnt);
        @(posedge clk24); #1;
        mem_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk24); #1;
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk24); #1;
        err_clr = 1'b0;
        m_err = 1'b0; m_addr = 32'd0; m_cnt = 0;
        @(negedge clk24);
        check_err_regs("clr");
        $display("clr err=%0d err_addr=%h err_cnt=%0d", err, err_addr, err_cnt);
        @(posedge clk24); #1;
    endtask

    initial begin
        #900_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation bound exceeded");
    end

    initial begin
        int slot;
        bit ready_seen;
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 32'd0;
        mem_wstrb = 4'd0;
        slv_rdata = '0;
        slv_rdy   = '0;
        err_clr   = 1'b0;
        m_err = 1'b0; m_addr = 32'd0; m_cnt = 0;
        #1;
        check_eq("rst_ready", 32'(mem_ready), 32'd0);
        check_eq("rst_sel",   32'(slv_sel),   32'd0);
        check_eq("rst_rdata", mem_rdata,      32'd0);
        check_err_regs("rst");
        repeat (2) @(posedge clk24);
        #1 reset = 1'b0;
        @(posedge clk24); #1;

        run_txn(32'h0000_0010, 0, 1'b0);
        run_txn(32'h1000_0004, 0, 1'b0);
        run_txn(32'h2000_0000, 0, 1'b0);
        run_txn(32'h3000_0008, 0, 1'b0);
        run_txn(32'h5000_0100, 0, 1'b0);
        run_txn(32'h4000_0020, 5, 1'b0);
        run_txn(32'h4000_0030, 16, 1'b0);
        run_txn(32'h4000_0040, 99, 1'b0);
        run_txn(32'h7000_0000, 0, 1'b0);
        run_txn(32'h7000_0004, 0, 1'b0);
        pulse_clr();
        run_txn(32'h6000_0000, 0, 1'b0);
        run_txn(32'h9000_0000, 0, 1'b1);

        // Request abandoned mid-WAIT must end silently.
        mem_valid = 1'b1;
        mem_addr  = 32'h5000_0000;
        repeat (3) begin
            @(posedge clk24); #1;
        end
        mem_valid  = 1'b0;
        ready_seen = 1'b0;
        repeat (10) begin
            @(negedge clk24);
            if (mem_ready) ready_seen = 1'b1;
            @(posedge clk24); #1;
        end
        check_eq("abort_no_ready", 32'(ready_seen), 32'd0);
        check_err_regs("abort");
        run_txn(32'h1000_0000, 0, 1'b0);

        // Asynchronous reset in the middle of a WAIT.
        mem_valid = 1'b1;
        mem_addr  = 32'h1000_0004;
        repeat (2) begin
            @(posedge clk24); #1;
        end
        reset = 1'b1;
        #1;
        m_err = 1'b0; m_addr = 32'd0; m_cnt = 0;
        check_eq("midrst_ready", 32'(mem_ready), 32'd0);
        check_eq("midrst_sel",   32'(slv_sel),   32'd0);
        check_err_regs("midrst");
        @(posedge clk24); #1;
        reset     = 1'b0;
        mem_valid = 1'b0;
        @(posedge clk24); #1;
        run_txn(32'h1000_0004, 0, 1'b0);

        for (int k = 0; k < 80; k++) begin
            slot = $urandom_range(0, 9);
            run_txn({4'(slot), 28'($urandom())}, $urandom_range(1, 18), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 9) == 0) pulse_clr();
        end

        // Saturation of the error counter.
        for (int k = 0; k < 258; k++) begin
            run_txn({4'($urandom_range(6, 15)), 28'($urandom())}, 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
